// File: rtl/ecc_banked_dp_ram.sv
// ecc_banked_dp_ram
//
// Dual-port RAM split into NUM_BANK banks. Each stored word is a Hamming SEC
// codeword. Reads are decoded, and any single-bit error is corrected on the
// way out.
//
// Parameters
//   WIDTH        data word width
//   ADDR_WIDTH   word address width (depth = 2**ADDR_WIDTH)
//   NUM_BANK     bank count, power of two in 2..8. The top address bits pick the bank.
//   READ_LATENCY cycles from an accepted read to o_valid_x, 1..4
//
// Ports (x = a | b)
//   i_clk, i_rst              clock; synchronous active-high reset
//   i_en_x, i_we_x            request strobe; 1 = write, 0 = read
//   i_addr_x, i_din_x         word address; write data
//   o_ready_x                 request accepted this cycle
//   o_valid_x                 read data presented this cycle
//   o_dout_x                  corrected read data
//   o_err_det_x, o_err_cor_x  error detected / corrected, qualified by o_valid_x
//   i_inj_mask_x              only when ECC_INJECT_EN is defined. XORed into the
//                             codeword stored by an accepted write.
//
// Optional feature macro: ECC_INJECT_EN (error-injection mask inputs).
//
// Handshake: a request on port x is taken in any cycle where i_en_x and
// o_ready_x are both 1. Port A is always ready out of reset. Port B is refused
// only when both ports request the same bank in the same cycle. In that case
// B must hold its request until it is accepted. Every accepted read produces
// exactly one o_valid_x pulse READ_LATENCY cycles later, in issue order.
// Writes never produce a pulse.

module ecc_banked_dp_ram #(
  parameter int WIDTH        = 8,
  parameter int ADDR_WIDTH   = 10,
  parameter int NUM_BANK     = 4,
  parameter int READ_LATENCY = 2,
  // The smallest p with 2**p >= WIDTH+p+1 is always clog2(WIDTH+1) or one more.
  localparam int P0          = $clog2(WIDTH + 1),
  localparam int PARITY      = ((2 ** P0) >= (WIDTH + P0 + 1)) ? P0 : P0 + 1,
  localparam int CODE_WIDTH  = WIDTH + PARITY
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
`ifdef ECC_INJECT_EN
  input  logic [CODE_WIDTH-1:0] i_inj_mask_a,
  input  logic [CODE_WIDTH-1:0] i_inj_mask_b,
`endif
  input  logic                  i_en_a,
  input  logic                  i_we_a,
  input  logic [ADDR_WIDTH-1:0] i_addr_a,
  input  logic [WIDTH-1:0]      i_din_a,
  input  logic                  i_en_b,
  input  logic                  i_we_b,
  input  logic [ADDR_WIDTH-1:0] i_addr_b,
  input  logic [WIDTH-1:0]      i_din_b,
  output logic                  o_ready_a,
  output logic                  o_ready_b,
  output logic [WIDTH-1:0]      o_dout_a,
  output logic [WIDTH-1:0]      o_dout_b,
  output logic                  o_valid_a,
  output logic                  o_valid_b,
  output logic                  o_err_det_a,
  output logic                  o_err_det_b,
  output logic                  o_err_cor_a,
  output logic                  o_err_cor_b
);

  localparam int BANK_BITS  = $clog2(NUM_BANK);
  localparam int ROW_W      = ADDR_WIDTH - BANK_BITS;
  localparam int BANK_DEPTH = 2 ** ROW_W;

  // Codeword bit i holds 1-based code position i+1. Parity bits sit at the
  // power-of-two positions. Data bits fill the other positions in ascending order.
  function automatic logic [CODE_WIDTH-1:0] f_encode(input logic [WIDTH-1:0] d);
    logic [CODE_WIDTH-1:0] c;
    logic                  x;
    int                    j;
    c = '0;
    j = 0;
    for (int p = 1; p <= CODE_WIDTH; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p-1] = d[j];
        j++;
      end
    end
    // Parity k covers every position with bit k set. The parity positions
    // are still zero here, so they add nothing to the sums.
    for (int k = 0; k < PARITY; k++) begin
      x = 1'b0;
      for (int p = 1; p <= CODE_WIDTH; p++) begin
        if (((p >> k) & 1) == 1) x = x ^ c[p-1];
      end
      c[(1 << k) - 1] = x;
    end
    return c;
  endfunction

  // Returns {det, cor, data}.
  function automatic logic [WIDTH+1:0] f_decode(input logic [CODE_WIDTH-1:0] c_in);
    logic [CODE_WIDTH-1:0] c;
    logic [PARITY-1:0]     s;
    logic [WIDTH-1:0]      d;
    logic                  det;
    logic                  cor;
    int                    j;
    c = c_in;
    s = '0;
    d = '0;
    j = 0;
    for (int p = 1; p <= CODE_WIDTH; p++) begin
      if (c[p-1]) s = s ^ PARITY'(p);
    end
    det = (s != '0);
    // A syndrome past the last code position cannot name a single-bit error,
    // so the data is passed through uncorrected.
    cor = det && (int'(s) <= CODE_WIDTH);
    for (int p = 1; p <= CODE_WIDTH; p++) begin
      if (cor && (PARITY'(p) == s)) c[p-1] = ~c[p-1];
    end
    for (int p = 1; p <= CODE_WIDTH; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[j] = c[p-1];
        j++;
      end
    end
    return {det, cor, d};
  endfunction

  logic [BANK_BITS-1:0]  w_bank_a, w_bank_b;
  logic [ROW_W-1:0]      w_row_a, w_row_b;
  logic                  w_conflict;
  logic                  w_acc_a, w_acc_b;
  logic                  w_wr_a, w_wr_b, w_rd_a, w_rd_b;
  logic [CODE_WIDTH-1:0] w_code_a, w_code_b;
  logic [WIDTH+1:0]      w_dec_a, w_dec_b;
  logic                  w_out_vld_a, w_out_vld_b;

  logic [CODE_WIDTH-1:0]   r_mem [NUM_BANK][BANK_DEPTH];
  logic [CODE_WIDTH-1:0]   r_code_a [READ_LATENCY];
  logic [CODE_WIDTH-1:0]   r_code_b [READ_LATENCY];
  logic [READ_LATENCY-1:0] r_vld_a, r_vld_b;

  assign w_bank_a = i_addr_a[ADDR_WIDTH-1 -: BANK_BITS];
  assign w_bank_b = i_addr_b[ADDR_WIDTH-1 -: BANK_BITS];
  assign w_row_a  = i_addr_a[ROW_W-1:0];
  assign w_row_b  = i_addr_b[ROW_W-1:0];

  assign w_conflict = i_en_a && i_en_b && (w_bank_a == w_bank_b);
  assign o_ready_a  = !i_rst;
  assign o_ready_b  = !i_rst && !w_conflict;

  assign w_acc_a = i_en_a && o_ready_a;
  assign w_acc_b = i_en_b && o_ready_b;
  assign w_wr_a  = w_acc_a && i_we_a;
  assign w_wr_b  = w_acc_b && i_we_b;
  assign w_rd_a  = w_acc_a && !i_we_a;
  assign w_rd_b  = w_acc_b && !i_we_b;

`ifdef ECC_INJECT_EN
  assign w_code_a = f_encode(i_din_a) ^ i_inj_mask_a;
  assign w_code_b = f_encode(i_din_b) ^ i_inj_mask_b;
`else
  assign w_code_a = f_encode(i_din_a);
  assign w_code_b = f_encode(i_din_b);
`endif

  // Storage and the read-data pipeline are not reset. Only the valid bits
  // below qualify what reaches the outputs. The two ports never write the
  // same bank in one cycle because port B is stalled on a bank clash. A read
  // issued the cycle after a write sees the write, since the array is
  // already updated at that edge.
  always_ff @(posedge i_clk) begin
    if (w_wr_a) r_mem[w_bank_a][w_row_a] <= w_code_a;
    if (w_wr_b) r_mem[w_bank_b][w_row_b] <= w_code_b;
    if (w_rd_a) r_code_a[0] <= r_mem[w_bank_a][w_row_a];
    if (w_rd_b) r_code_b[0] <= r_mem[w_bank_b][w_row_b];
    for (int i = 1; i < READ_LATENCY; i++) begin
      r_code_a[i] <= r_code_a[i-1];
      r_code_b[i] <= r_code_b[i-1];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld_a <= '0;
      r_vld_b <= '0;
    end else begin
      r_vld_a[0] <= w_rd_a;
      r_vld_b[0] <= w_rd_b;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_vld_a[i] <= r_vld_a[i-1];
        r_vld_b[i] <= r_vld_b[i-1];
      end
    end
  end

  assign w_dec_a = f_decode(r_code_a[READ_LATENCY-1]);
  assign w_dec_b = f_decode(r_code_b[READ_LATENCY-1]);

  // Outputs are also forced low during the reset cycle itself. The valid
  // stages only clear at the first reset edge.
  assign w_out_vld_a = r_vld_a[READ_LATENCY-1] && !i_rst;
  assign w_out_vld_b = r_vld_b[READ_LATENCY-1] && !i_rst;

  assign o_valid_a   = w_out_vld_a;
  assign o_valid_b   = w_out_vld_b;
  assign o_dout_a    = w_out_vld_a ? w_dec_a[WIDTH-1:0] : '0;
  assign o_dout_b    = w_out_vld_b ? w_dec_b[WIDTH-1:0] : '0;
  assign o_err_det_a = w_out_vld_a && w_dec_a[WIDTH+1];
  assign o_err_det_b = w_out_vld_b && w_dec_b[WIDTH+1];
  assign o_err_cor_a = w_out_vld_a && w_dec_a[WIDTH];
  assign o_err_cor_b = w_out_vld_b && w_dec_b[WIDTH];

endmodule

// File: tb/tb_ecc_banked_dp_ram.sv
// tb_ecc_banked_dp_ram
//
// Drives both ports of ecc_banked_dp_ram with directed and random requests.
// The reference model is a plain array of the words the bench expects back
// ({det, cor, data}), indexed by address. Port B is accepted unless both
// ports hit the same bank. Each accepted read pushes its expected response
// and due cycle onto a per-port queue. A negedge monitor pops an entry on
// every o_valid pulse and checks latency, data and flags.

module tb_ecc_banked_dp_ram;
  localparam int WIDTH        = 8;
  localparam int ADDR_WIDTH   = 10;
  localparam int NUM_BANK     = 4;
  localparam int READ_LATENCY = 2;
  localparam int BANK_BITS    = 2;
  localparam int EW           = 32 + 2 + WIDTH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic                  rst;
  logic                  i_en_a, i_we_a, i_en_b, i_we_b;
  logic [ADDR_WIDTH-1:0] i_addr_a, i_addr_b;
  logic [WIDTH-1:0]      i_din_a, i_din_b;
  logic                  o_ready_a, o_ready_b, o_valid_a, o_valid_b;
  logic [WIDTH-1:0]      o_dout_a, o_dout_b;
  logic                  o_err_det_a, o_err_det_b, o_err_cor_a, o_err_cor_b;
`ifdef ECC_INJECT_EN
  logic [11:0]           mask_a, mask_b;
`endif

  ecc_banked_dp_ram #(
    .WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .NUM_BANK(NUM_BANK), .READ_LATENCY(READ_LATENCY)
  ) dut (
    .i_clk(clk), .i_rst(rst),
`ifdef ECC_INJECT_EN
    .i_inj_mask_a(mask_a), .i_inj_mask_b(mask_b),
`endif
    .i_en_a(i_en_a), .i_we_a(i_we_a), .i_addr_a(i_addr_a), .i_din_a(i_din_a),
    .i_en_b(i_en_b), .i_we_b(i_we_b), .i_addr_b(i_addr_b), .i_din_b(i_din_b),
    .o_ready_a(o_ready_a), .o_ready_b(o_ready_b),
    .o_dout_a(o_dout_a), .o_dout_b(o_dout_b),
    .o_valid_a(o_valid_a), .o_valid_b(o_valid_b),
    .o_err_det_a(o_err_det_a), .o_err_det_b(o_err_det_b),
    .o_err_cor_a(o_err_cor_a), .o_err_cor_b(o_err_cor_b)
  );

  // Reference model: {det, cor, data} expected on a read of each address.
  logic [WIDTH+1:0] model [2**ADDR_WIDTH];
  bit               written [2**ADDR_WIDTH];
  logic [EW-1:0]    exp_q_a[$];
  logic [EW-1:0]    exp_q_b[$];
  int               n_tests = 0;
  int               n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic mon_port(input int p, input logic v, input logic [WIDTH-1:0] d,
                          input logic det, input logic cor);
    logic [EW-1:0] e;
    int            qs;
    string         nm;
    nm = (p == 0) ? "A" : "B";
    qs = (p == 0) ? exp_q_a.size() : exp_q_b.size();
    if (v) begin
      if (qs == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL valid_%s: o_valid=1 with no read outstanding (cycle %0d)", nm, cyc);
      end else begin
        if (p == 0) e = exp_q_a.pop_front();
        else        e = exp_q_b.pop_front();
        check({"latency_", nm}, cyc, e[EW-1 -: 32]);
        check({"dout_", nm}, 32'(d), 32'(e[WIDTH-1:0]));
        check({"det_", nm}, 32'(det), 32'(e[WIDTH+1]));
        check({"cor_", nm}, 32'(cor), 32'(e[WIDTH]));
      end
    end else begin
      check({"idle_zero_", nm}, {23'b0, d, det, cor}, 32'h0);
      if (qs > 0) begin
        if (p == 0) e = exp_q_a[0];
        else        e = exp_q_b[0];
        if (int'(e[EW-1 -: 32]) <= cyc) begin
          n_tests++;
          n_fail++;
          $display("FAIL missing_valid_%s: o_valid=0, expected a pulse due at cycle %0d", nm,
                   int'(e[EW-1 -: 32]));
          if (p == 0) void'(exp_q_a.pop_front());
          else        void'(exp_q_b.pop_front());
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon_port(0, o_valid_a, o_dout_a, o_err_det_a, o_err_cor_a);
    mon_port(1, o_valid_b, o_dout_b, o_err_det_b, o_err_cor_b);
  end

  // ---------------- driver ----------------
  task automatic accept_port(input int p, input logic we, input logic [ADDR_WIDTH-1:0] a,
                             input logic [WIDTH-1:0] d);
    if (we) begin
      model[a]   = {2'b00, d};
      written[a] = 1'b1;
    end else if (p == 0) begin
      exp_q_a.push_back({32'(cyc + READ_LATENCY), model[a]});
    end else begin
      exp_q_b.push_back({32'(cyc + READ_LATENCY), model[a]});
    end
  endtask

  // Called just after a posedge. Applies one cycle of requests, checks
  // ready at the negedge, updates the model and returns after the next posedge.
  task automatic step(input logic ea, input logic wa, input logic [ADDR_WIDTH-1:0] aa,
                      input logic [WIDTH-1:0] da,
                      input logic eb, input logic wb, input logic [ADDR_WIDTH-1:0] ab,
                      input logic [WIDTH-1:0] db, output logic acc_b);
    logic exp_rb;
    i_en_a = ea; i_we_a = wa; i_addr_a = aa; i_din_a = da;
    i_en_b = eb; i_we_b = wb; i_addr_b = ab; i_din_b = db;
    @(negedge clk);
    if (rst) begin
      check("ready_a_in_reset", 32'(o_ready_a), 32'h0);
      check("ready_b_in_reset", 32'(o_ready_b), 32'h0);
      check("valid_in_reset", {30'b0, o_valid_a, o_valid_b}, 32'h0);
      acc_b = 1'b0;
    end else begin
      exp_rb = !(ea && eb && (aa[ADDR_WIDTH-1 -: BANK_BITS] == ab[ADDR_WIDTH-1 -: BANK_BITS]));
      check("ready_a", 32'(o_ready_a), 32'h1);
      check("ready_b", 32'(o_ready_b), 32'(exp_rb));
      if (ea) accept_port(0, wa, aa, da);
      if (eb && exp_rb) accept_port(1, wb, ab, db);
      acc_b = eb && exp_rb;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, 0, '0, '0, acc);
  endtask

  function automatic logic [ADDR_WIDTH-1:0] rand_addr();
    logic [BANK_BITS-1:0] bk;
    logic [3:0]           rw;
    bk = BANK_BITS'($urandom_range(0, NUM_BANK - 1));
    rw = 4'($urandom_range(0, 15));
    return {bk, 4'b0000, rw};
  endfunction

  // ---------------- stimulus ----------------
  initial begin : stim
    logic                  acc, ea, wa, eb, wb, pend_b;
    logic [ADDR_WIDTH-1:0] aa, ab;
    logic [WIDTH-1:0]      da, db;
    int                    hold;

    rst = 1'b1;
    i_en_a = 0; i_we_a = 0; i_addr_a = '0; i_din_a = '0;
    i_en_b = 0; i_we_b = 0; i_addr_b = '0; i_din_b = '0;
`ifdef ECC_INJECT_EN
    mask_a = '0; mask_b = '0;
`endif
    @(posedge clk);
    #1;
    // Requests during reset are refused and all outputs stay low.
    step(1, 1, 10'h005, 8'h11, 1, 1, 10'h105, 8'h22, acc);
    step(1, 0, 10'h005, 8'h00, 1, 0, 10'h105, 8'h00, acc);
    rst = 1'b0;

    // Write then read the next cycle.
    step(1, 1, 10'h005, 8'hA5, 0, 0, '0, '0, acc);
    step(1, 0, 10'h005, 8'h00, 0, 0, '0, '0, acc);
    idle(3);

    // Same-bank clash: B stalls one cycle, then goes through.
    step(1, 1, 10'h010, 8'h5C, 0, 0, '0, '0, acc);
    step(0, 0, '0, '0, 1, 1, 10'h020, 8'hE7, acc);
    step(1, 0, 10'h010, 8'h00, 1, 0, 10'h020, 8'h00, acc);
    check("b_stalled_on_clash", 32'(acc), 32'h0);
    step(0, 0, '0, '0, 1, 0, 10'h020, 8'h00, acc);
    check("b_accepted_after_clash", 32'(acc), 32'h1);
    idle(3);

    // Different banks in the same cycle.
    step(1, 1, 10'h100, 8'h3C, 1, 1, 10'h300, 8'hC3, acc);
    step(1, 0, 10'h100, 8'h00, 1, 0, 10'h300, 8'h00, acc);
    idle(3);

    // Eight back-to-back reads on B, rotating banks.
    for (int i = 0; i < 8; i++)
      step(1, 1, {BANK_BITS'(i % NUM_BANK), 8'(8'h40 + i)}, 8'($urandom), 0, 0, '0, '0, acc);
    for (int i = 0; i < 8; i++)
      step(0, 0, '0, '0, 1, 0, {BANK_BITS'(i % NUM_BANK), 8'(8'h40 + i)}, 8'h00, acc);
    idle(3);

    // Random traffic. A stalled B request is held until accepted.
    pend_b = 1'b0;
    hold   = 0;
    eb = 0; wb = 0; ab = '0; db = '0;
    for (int n = 0; n < 400; n++) begin
      ea = 1'($urandom_range(0, 1));
      aa = rand_addr();
      wa = ($urandom_range(0, 2) == 0) || !written[aa];
      da = 8'($urandom);
      if (!pend_b) begin
        eb = 1'($urandom_range(0, 1));
        ab = rand_addr();
        wb = ($urandom_range(0, 2) == 0) || !written[ab];
        db = 8'($urandom);
      end
      if (hold >= 4) ea = 1'b0;
      step(ea, wa, aa, da, eb, wb, ab, db, acc);
      pend_b = eb && !acc;
      hold   = pend_b ? hold + 1 : 0;
    end
    idle(4);

`ifdef ECC_INJECT_EN
    // Single-bit flip at position 3: corrected.
    mask_a = 12'h004;
    step(1, 1, 10'h2F0, 8'h5A, 0, 0, '0, '0, acc);
    model[10'h2F0] = {1'b1, 1'b1, 8'h5A};
    // Positions 1 and 2 flipped: syndrome 3 miscorrects data bit 0.
    mask_a = 12'h003;
    step(1, 1, 10'h2F1, 8'h5A, 0, 0, '0, '0, acc);
    model[10'h2F1] = {1'b1, 1'b1, 8'h5B};
    // Positions 1 and 12: syndrome 13 is past the codeword, so nothing is
    // corrected and data bit 7 stays flipped.
    mask_a = 12'h801;
    step(1, 1, 10'h2F2, 8'h5A, 0, 0, '0, '0, acc);
    model[10'h2F2] = {1'b1, 1'b0, 8'hDA};
    mask_a = '0;
    // Port B mask, single flip at position 12.
    mask_b = 12'h800;
    step(0, 0, '0, '0, 1, 1, 10'h3F0, 8'h81, acc);
    model[10'h3F0] = {1'b1, 1'b1, 8'h81};
    mask_b = '0;
    step(1, 0, 10'h2F0, 8'h00, 1, 0, 10'h3F0, 8'h00, acc);
    step(1, 0, 10'h2F1, 8'h00, 0, 0, '0, '0, acc);
    step(1, 0, 10'h2F2, 8'h00, 0, 0, '0, '0, acc);
    idle(4);
`endif

    // Reads at N and N+1, reset in N+1: the in-flight read is dropped.
    step(1, 0, 10'h005, 8'h00, 0, 0, '0, '0, acc);
    rst = 1'b1;
    exp_q_a.delete();
    exp_q_b.delete();
    step(1, 0, 10'h005, 8'h00, 1, 0, 10'h100, 8'h00, acc);
    rst = 1'b0;
    idle(4);

    // Reset lands in the cycle the read result would appear.
    step(1, 0, 10'h005, 8'h00, 1, 0, 10'h100, 8'h00, acc);
    idle(1);
    rst = 1'b1;
    exp_q_a.delete();
    exp_q_b.delete();
    idle(1);
    rst = 1'b0;
    idle(3);

    // Normal operation resumes after reset.
    step(1, 0, 10'h005, 8'h00, 1, 0, 10'h300, 8'h00, acc);
    idle(6);

    check("drain_a", exp_q_a.size(), 32'h0);
    check("drain_b", exp_q_b.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
